// File: rtl/uart_8n1_rx_controller_pkg.sv
// Shared types and constants for the UART 8N1 receive controller.
//   state_e                 : controller FSM encoding (2 bits)
//   DATA_W                  : byte width carried through the FIFO
//   UART_IDLE_TICKS_DEFAULT : idle-high clocks required after an error frame
package uart_8n1_rx_controller_pkg;

  localparam int unsigned DATA_W                  = 8;
  localparam int unsigned UART_IDLE_TICKS_DEFAULT = 160;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_RECV    = 2'd2,
    ST_HOLDOFF = 2'd3
  } state_e;

endpackage

// File: rtl/uart_byte_fifo.sv
// Show-ahead byte FIFO.
//   clk, rst_n  : clock, async active-low reset
//   push, din   : write request and data (ignored when full unless a pop happens too)
//   pop         : read request (ignored when empty)
//   dout        : head entry, 0 when empty
//   full, empty : occupancy flags
//   level       : current occupancy
module uart_byte_fifo
  import uart_8n1_rx_controller_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DATA_W-1:0]        din,
  output logic [DATA_W-1:0]        dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  // A pop frees the slot, so a push into a full FIFO is allowed in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign full  = (level == LVL_W'(DEPTH));
  assign empty = (level == '0);
  assign dout  = empty ? '0 : mem[rd_ptr];

  // Storage array
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally at the power-of-2 depth
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/uart_8n1_rx_controller.sv
// Sequencer for a uart_8n1_receiver: re-arms it after every frame, buffers good
// bytes in a FIFO with a valid/ready consumer port, and holds off after an error
// frame until rx has been idle-high for IDLE_TICKS clocks.
//   clk_baud_16x, reset_n           : 16x baud clock, async active-low reset
//   enable                          : keep receiving; 0 stops after the current frame
//   rx                              : raw line, synchronised, used only for hold-off
//   recv_read / recv_busy /
//   recv_error / recv_data          : receiver handshake
//   out_data / out_valid / out_ready: show-ahead consumer port
//   fifo_level                      : FIFO occupancy
//   err_count, overflow,
//   status_clear                    : saturating error count, sticky drop flag, clear
module uart_8n1_rx_controller
  import uart_8n1_rx_controller_pkg::*;
#(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned IDLE_TICKS = UART_IDLE_TICKS_DEFAULT
) (
  input  logic                   clk_baud_16x,
  input  logic                   reset_n,
  input  logic                   enable,
  input  logic                   rx,
  output logic                   recv_read,
  input  logic                   recv_busy,
  input  logic                   recv_error,
  input  logic [DATA_W-1:0]      recv_data,
  output logic [DATA_W-1:0]      out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic [7:0]             err_count,
  output logic                   overflow,
  input  logic                   status_clear
);

  localparam int unsigned CNT_W = $clog2(IDLE_TICKS);

  state_e           state;
  state_e           state_nxt;
  logic             rx_meta;
  logic             rx_s;
  logic [CNT_W-1:0] hcnt;
  logic             holdoff_done;
  logic             frame_end;
  logic             good_frame;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;

  assign frame_end    = (state == ST_RECV) && !recv_busy;
  assign good_frame   = frame_end && !recv_error;
  assign pop          = !fifo_empty && out_ready;
  assign push         = good_frame && (!fifo_full || pop);
  assign holdoff_done = (state == ST_HOLDOFF) && rx_s && (hcnt == CNT_W'(IDLE_TICKS - 1));
  assign out_valid    = !fifo_empty;

  uart_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk_baud_16x),
    .rst_n (reset_n),
    .push  (push),
    .pop   (pop),
    .din   (recv_data),
    .dout  (out_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (enable) state_nxt = ST_ARM;
      ST_ARM:     if (recv_busy) state_nxt = ST_RECV;
      ST_RECV: begin
        if (!recv_busy) begin
          if (recv_error)  state_nxt = ST_HOLDOFF;
          else if (enable) state_nxt = ST_ARM;
          else             state_nxt = ST_IDLE;
        end
      end
      ST_HOLDOFF: if (holdoff_done) state_nxt = enable ? ST_ARM : ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // State register; recv_read is registered from the next state so it tracks ARM exactly
  always_ff @(posedge clk_baud_16x or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      recv_read <= 1'b0;
    end else begin
      state     <= state_nxt;
      recv_read <= (state_nxt == ST_ARM);
    end
  end

  // Two-flop rx synchroniser, reset to the idle-high line level
  always_ff @(posedge clk_baud_16x or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // Consecutive idle-high counter, only live in HOLDOFF
  always_ff @(posedge clk_baud_16x or negedge reset_n) begin
    if (!reset_n) begin
      hcnt <= '0;
    end else if (state != ST_HOLDOFF || !rx_s || holdoff_done) begin
      hcnt <= '0;
    end else begin
      hcnt <= hcnt + CNT_W'(1);
    end
  end

  // Status: clear has priority over a same-cycle increment or set
  always_ff @(posedge clk_baud_16x or negedge reset_n) begin
    if (!reset_n) begin
      err_count <= '0;
      overflow  <= 1'b0;
    end else if (status_clear) begin
      err_count <= '0;
      overflow  <= 1'b0;
    end else begin
      if (frame_end && recv_error && err_count != 8'hff) err_count <= err_count + 8'd1;
      if (good_frame && fifo_full && !pop)                overflow  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_8n1_rx_controller.sv
// Bench for uart_8n1_rx_controller with a behavioural 8N1 receiver (16 clocks per bit).
module tb_uart_8n1_rx_controller;

  localparam int unsigned IDLE_TICKS = 160;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       enable;
  logic       rx;
  logic       recv_read;
  logic       recv_busy;
  logic       recv_error;
  logic [7:0] recv_data;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] fifo_level;
  logic [7:0] err_count;
  logic       overflow;
  logic       status_clear;

  int checks = 0;
  int errors = 0;
  logic [7:0] sb[$];
  logic [7:0] sb_exp;

  always #5 clk = ~clk;

  uart_8n1_rx_controller #(.DEPTH(4), .IDLE_TICKS(IDLE_TICKS)) dut (
    .clk_baud_16x (clk),
    .reset_n      (reset_n),
    .enable       (enable),
    .rx           (rx),
    .recv_read    (recv_read),
    .recv_busy    (recv_busy),
    .recv_error   (recv_error),
    .recv_data    (recv_data),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .fifo_level   (fifo_level),
    .err_count    (err_count),
    .overflow     (overflow),
    .status_clear (status_clear)
  );

  // Behavioural receiver: a recv_read while idle starts a receive cycle; bits are
  // sampled mid-bit and busy drops in the middle of the stop bit.
  logic [1:0] m_st;
  logic [7:0] m_cnt;
  logic [7:0] m_shift;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_st <= 2'd0; m_cnt <= 8'd0; m_shift <= 8'd0;
      recv_busy <= 1'b0; recv_error <= 1'b0; recv_data <= 8'd0;
    end else begin
      case (m_st)
        2'd0: if (recv_read) begin recv_busy <= 1'b1; recv_error <= 1'b0; m_st <= 2'd1; end
        2'd1: if (!rx) begin m_cnt <= 8'd0; m_st <= 2'd2; end
        default: begin
          m_cnt <= m_cnt + 8'd1;
          if (m_cnt[3:0] == 4'd8 && m_cnt >= 8'd24 && m_cnt < 8'd152) m_shift <= {rx, m_shift[7:1]};
          if (m_cnt == 8'd152) begin
            recv_error <= !rx; recv_data <= m_shift; recv_busy <= 1'b0; m_st <= 2'd0;
          end
        end
      endcase
    end
  end

  // Scoreboard: every consumer pop is compared with the oldest expected byte
  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got %02h, expected nothing", out_data);
      end else begin
        sb_exp = sb.pop_front();
        if (out_data !== sb_exp) begin
          errors++;
          $display("FAIL sb_data: got %02h, expected %02h", out_data, sb_exp);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    rx = 1'b0;
    repeat (16) tick();
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (16) tick();
    end
    rx = stop;
    repeat (16) tick();
    rx = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] d);
    send_frame(d, 1'b1);
    repeat (24) tick();
  endtask

  task automatic drain(input string name);
    out_ready = 1'b1;
    for (int i = 0; i < 200 && sb.size() != 0; i++) tick();
    tick();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d bytes still expected", name, sb.size());
    end
    checks++;
    if (fifo_level !== 3'd0) begin
      errors++;
      $display("FAIL %s_level_after_drain: got %0d, expected 0", name, fifo_level);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; enable = 1'b0; rx = 1'b1; out_ready = 1'b0; status_clear = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (recv_read !== 1'b0)  begin errors++; $display("FAIL rst_recv_read: got %b, expected 0", recv_read); end
    checks++; if (out_valid !== 1'b0)  begin errors++; $display("FAIL rst_out_valid: got %b, expected 0", out_valid); end
    checks++; if (out_data !== 8'h00)  begin errors++; $display("FAIL rst_out_data: got %02h, expected 00", out_data); end
    checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL rst_level: got %0d, expected 0", fifo_level); end
    checks++; if (err_count !== 8'd0)  begin errors++; $display("FAIL rst_err_count: got %0d, expected 0", err_count); end
    checks++; if (overflow !== 1'b0)   begin errors++; $display("FAIL rst_overflow: got %b, expected 0", overflow); end
    reset_n = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_basic();
    enable = 1'b1; out_ready = 1'b1;
    repeat (4) tick();
    sb.push_back(8'hA5); send_byte(8'hA5);
    sb.push_back(8'h3C); send_byte(8'h3C);
    drain("basic");
    checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL basic_err_count: got %0d, expected 0", err_count); end
    checks++; if (overflow !== 1'b0)  begin errors++; $display("FAIL basic_overflow: got %b, expected 0", overflow); end
  endtask

  task automatic test_overflow();
    out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      if (i <= 4) sb.push_back(8'(i));
      send_byte(8'(i));
    end
    checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL ovf_level: got %0d, expected 4", fifo_level); end
    checks++; if (overflow !== 1'b1)   begin errors++; $display("FAIL ovf_flag: got %b, expected 1", overflow); end
    checks++; if (out_data !== 8'h01)  begin errors++; $display("FAIL ovf_head: got %02h, expected 01", out_data); end
    status_clear = 1'b1; tick(); status_clear = 1'b0;
    checks++; if (overflow !== 1'b0)   begin errors++; $display("FAIL ovf_clear: got %b, expected 0", overflow); end
    drain("ovf");
    out_ready = 1'b0;
  endtask

  task automatic test_error_holdoff();
    int n;
    send_frame(8'h55, 1'b0);
    rx = 1'b0;
    repeat (50) tick();
    checks++; if (err_count !== 8'd1)  begin errors++; $display("FAIL err_count: got %0d, expected 1", err_count); end
    checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL err_no_push: got level %0d, expected 0", fifo_level); end
    checks++; if (recv_read !== 1'b0)  begin errors++; $display("FAIL err_holdoff_read: got %b, expected 0", recv_read); end
    rx = 1'b1;
    n = 0;
    while (!recv_read && n < 400) begin tick(); n++; end
    // IDLE_TICKS idle clocks counted after the two-flop synchroniser delay
    checks++;
    if (n != IDLE_TICKS + 2) begin
      errors++; $display("FAIL err_rearm_latency: got %0d clocks, expected %0d", n, IDLE_TICKS + 2);
    end
    repeat (24) tick();
  endtask

  task automatic test_disable_midframe();
    int seen;
    out_ready = 1'b1;
    sb.push_back(8'h7E);
    fork
      send_byte(8'h7E);
      begin repeat (80) tick(); enable = 1'b0; end
    join
    drain("dis");
    seen = 0;
    repeat (40) begin tick(); if (recv_read) seen++; end
    checks++; if (seen != 0) begin errors++; $display("FAIL dis_recv_read: got %0d cycles high, expected 0", seen); end
  endtask

  task automatic test_full_pop_push();
    int b;
    enable = 1'b1; out_ready = 1'b0;
    repeat (4) tick();
    sb.push_back(8'h11); send_byte(8'h11);
    sb.push_back(8'h22); send_byte(8'h22);
    sb.push_back(8'h33); send_byte(8'h33);
    sb.push_back(8'h44); send_byte(8'h44);
    checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL full_level_pre: got %0d, expected 4", fifo_level); end
    sb.push_back(8'h99);
    b = 0;
    fork
      send_byte(8'h99);
      begin
        while (recv_busy && b < 400) begin tick(); b++; end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
      end
    join
    checks++; if (b >= 400) begin errors++; $display("FAIL full_timeout: busy never dropped"); end
    checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL full_level: got %0d, expected 4", fifo_level); end
    checks++; if (overflow !== 1'b0)   begin errors++; $display("FAIL full_overflow: got %b, expected 0", overflow); end
    checks++; if (out_data !== 8'h22)  begin errors++; $display("FAIL full_head: got %02h, expected 22", out_data); end
    drain("full");
    out_ready = 1'b0;
  endtask

  task automatic test_reset_midframe();
    out_ready = 1'b0;
    send_byte(8'h5A);
    checks++; if (fifo_level !== 3'd1) begin errors++; $display("FAIL mrst_level_pre: got %0d, expected 1", fifo_level); end
    fork
      send_frame(8'hF0, 1'b1);
      begin
        repeat (100) tick();
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        checks++; if (recv_read !== 1'b0)  begin errors++; $display("FAIL mrst_recv_read: got %b, expected 0", recv_read); end
        checks++; if (out_valid !== 1'b0)  begin errors++; $display("FAIL mrst_out_valid: got %b, expected 0", out_valid); end
        checks++; if (out_data !== 8'h00)  begin errors++; $display("FAIL mrst_out_data: got %02h, expected 00", out_data); end
        checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL mrst_level: got %0d, expected 0", fifo_level); end
        checks++; if (err_count !== 8'd0)  begin errors++; $display("FAIL mrst_err_count: got %0d, expected 0", err_count); end
        checks++; if (overflow !== 1'b0)   begin errors++; $display("FAIL mrst_overflow: got %b, expected 0", overflow); end
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        checks++; if (recv_read !== 1'b1)  begin errors++; $display("FAIL mrst_arm: got %b, expected 1", recv_read); end
      end
    join
    sb.delete();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_error_holdoff();
    test_disable_midframe();
    test_full_pop_push();
    test_reset_midframe();
    repeat (5) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
